// File: rtl/bt_target_pipe_pkg.sv
// Shared core package slice used by the branch-target unit.
// Holds the operand-select enums shared with the decoder, plus the PC
// increment constants used for the link address and the PC-increment operand.
package bt_target_pipe_pkg;

    // Operand A selection: only REG_A picks rs1; every other code selects the PC.
    typedef enum logic [1:0] {
        OP_A_REG_A  = 2'd0,
        OP_A_FWD    = 2'd1,
        OP_A_CURRPC = 2'd2,
        OP_A_IMM    = 2'd3
    } op_a_sel_e;

    // Operand B selection: I/B/J immediates or the PC increment; any other
    // code falls back to the increment.
    typedef enum logic [2:0] {
        IMM_B_I         = 3'd0,
        IMM_B_S         = 3'd1,
        IMM_B_B         = 3'd2,
        IMM_B_U         = 3'd3,
        IMM_B_J         = 3'd4,
        IMM_B_INCR_PC   = 3'd5,
        IMM_B_INCR_ADDR = 3'd6
    } imm_b_sel_e;

    localparam int BT_INCR_C = 2;  // 16-bit instruction
    localparam int BT_INCR_W = 4;  // 32-bit instruction

endpackage

// File: rtl/bt_target_pipe_if.sv
// Bus bundle for the branch-target unit.
// master: EX-stage driver (op inputs, flush, downstream ready).
// slave : bt_target_pipe (ready_o, result outputs, occupancy).
interface bt_target_pipe_if #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
);
    import bt_target_pipe_pkg::*;

    localparam int OCC_W = $clog2(STAGES + 1);

    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    op_a_sel_e        bt_a_mux_sel_i;
    imm_b_sel_e       bt_b_mux_sel_i;
    logic [XLEN-1:0]  imm_i_type_i;
    logic [XLEN-1:0]  imm_b_type_i;
    logic [XLEN-1:0]  imm_j_type_i;
    logic [XLEN-1:0]  rf_rdata_a_i;
    logic [XLEN-1:0]  pc_i;
    logic             instr_is_compressed_i;
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  target_o;
    logic [XLEN-1:0]  link_o;
    logic             misaligned_o;
    logic [OCC_W-1:0] occupancy_o;

    modport master (
        output flush_i, valid_i, bt_a_mux_sel_i, bt_b_mux_sel_i,
               imm_i_type_i, imm_b_type_i, imm_j_type_i, rf_rdata_a_i,
               pc_i, instr_is_compressed_i, ready_i,
        input  ready_o, valid_o, target_o, link_o, misaligned_o, occupancy_o
    );

    modport slave (
        input  flush_i, valid_i, bt_a_mux_sel_i, bt_b_mux_sel_i,
               imm_i_type_i, imm_b_type_i, imm_j_type_i, rf_rdata_a_i,
               pc_i, instr_is_compressed_i, ready_i,
        output ready_o, valid_o, target_o, link_o, misaligned_o, occupancy_o
    );

endinterface

// File: rtl/bt_pipe_stage.sv
// One elastic pipeline register with valid/ready/flush.
// Ports: clk, rst (sync, active-high), flush; in_vld/in_data from the previous
// stage; rdy = this stage can accept, rdy_nxt = next stage can accept (both
// computed by the parent); out_vld/out_data registered toward the next stage.
module bt_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    input  logic         rdy,
    input  logic         rdy_nxt,
    output logic         out_vld,
    output logic [W-1:0] out_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (flush) begin
            // Data is left stale; only the valid bit matters.
            out_vld <= 1'b0;
        end else if (in_vld && rdy) begin
            out_vld  <= 1'b1;
            out_data <= in_data;
        end else if (rdy_nxt) begin
            // Content moved on and nothing replaced it.
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/bt_target_pipe.sv
// Pipelined branch-target unit for the EX stage.
// Selects operand A (rs1 or PC) and B (I/B/J immediate or PC increment), adds
// them, clears bit 0 for JALR, computes the link address and the misalignment
// flag, then pushes {misaligned, link, target} through STAGES elastic stages.
// Ports: clk_i, rst_i (sync, active-high); bus (slave modport) carries the
// op inputs, flush, valid/ready handshakes, results and occupancy.
module bt_target_pipe
    import bt_target_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int RV32C  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bt_target_pipe_if.slave   bus
);

    localparam int PW    = 2 * XLEN + 1;
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [XLEN-1:0] op_a, op_b, incr, sum, target, link;
    logic            is_jalr, mis;

    // ---------------- combinational front end ----------------
    always_comb begin
        incr = (RV32C != 0 && bus.instr_is_compressed_i) ? XLEN'(BT_INCR_C)
                                                         : XLEN'(BT_INCR_W);
        op_a = (bus.bt_a_mux_sel_i == OP_A_REG_A) ? bus.rf_rdata_a_i : bus.pc_i;
        case (bus.bt_b_mux_sel_i)
            IMM_B_I: op_b = bus.imm_i_type_i;
            IMM_B_B: op_b = bus.imm_b_type_i;
            IMM_B_J: op_b = bus.imm_j_type_i;
            default: op_b = incr;
        endcase
        sum     = op_a + op_b;
        is_jalr = (bus.bt_a_mux_sel_i == OP_A_REG_A) && (bus.bt_b_mux_sel_i == IMM_B_I);
        target  = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
        link    = bus.pc_i + incr;
    end

    generate
        if (RV32C != 0) begin : g_align_c
            assign mis = target[0];
        end else begin : g_align_w
            assign mis = |target[1:0];
        end
    endgenerate

    // ---------------- elastic stage chain ----------------
    logic [STAGES:0]          vld_pipe;
    logic [STAGES:0][PW-1:0]  dat_pipe;
    logic [STAGES+1:1]        rdy;
    logic                     all_v;

    assign vld_pipe[0] = bus.valid_i;
    assign dat_pipe[0] = {mis, link, target};

    // rdy[k] = ~vld[k] | rdy[k+1], unrolled: stage k stalls only when it and
    // every stage after it are valid while downstream is not ready. Computed
    // from registered valids so there is no combinational chain between stages.
    always_comb begin
        all_v        = 1'b1;
        rdy          = '0;
        rdy[STAGES+1] = bus.ready_i;
        for (int k = STAGES; k >= 1; k--) begin
            all_v  = all_v & vld_pipe[k];
            rdy[k] = bus.ready_i | ~all_v;
        end
    end

    generate
        for (genvar k = 1; k <= STAGES; k++) begin : g_stg
            bt_pipe_stage #(.W(PW)) u_stg (
                .clk      (clk_i),
                .rst      (rst_i),
                .flush    (bus.flush_i),
                .in_vld   (vld_pipe[k-1]),
                .in_data  (dat_pipe[k-1]),
                .rdy      (rdy[k]),
                .rdy_nxt  (rdy[k+1]),
                .out_vld  (vld_pipe[k]),
                .out_data (dat_pipe[k])
            );
        end
    endgenerate

    // ---------------- outputs ----------------
    logic [OCC_W-1:0] occ;

    always_comb begin
        occ = '0;
        for (int k = 1; k <= STAGES; k++) occ = occ + OCC_W'(vld_pipe[k]);
    end

    assign bus.ready_o     = rdy[1];
    assign bus.valid_o     = vld_pipe[STAGES];
    assign bus.occupancy_o = occ;
    assign {bus.misaligned_o, bus.link_o, bus.target_o} = dat_pipe[STAGES];

endmodule

// File: tb/tb_bt_target_pipe.sv
// Directed bench for bt_target_pipe: two instances (RV32C=1 and RV32C=0) share
// one stimulus stream; expected values are hand-computed constants plus a
// small in-order queue for the streaming/backpressure section.
module tb_bt_target_pipe;
    import bt_target_pipe_pkg::*;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bt_target_pipe_if #(.XLEN(XLEN), .STAGES(STAGES)) bus  ();
    bt_target_pipe_if #(.XLEN(XLEN), .STAGES(STAGES)) bus4 ();

    assign bus4.flush_i               = bus.flush_i;
    assign bus4.valid_i               = bus.valid_i;
    assign bus4.bt_a_mux_sel_i        = bus.bt_a_mux_sel_i;
    assign bus4.bt_b_mux_sel_i        = bus.bt_b_mux_sel_i;
    assign bus4.imm_i_type_i          = bus.imm_i_type_i;
    assign bus4.imm_b_type_i          = bus.imm_b_type_i;
    assign bus4.imm_j_type_i          = bus.imm_j_type_i;
    assign bus4.rf_rdata_a_i          = bus.rf_rdata_a_i;
    assign bus4.pc_i                  = bus.pc_i;
    assign bus4.instr_is_compressed_i = bus.instr_is_compressed_i;
    assign bus4.ready_i               = bus.ready_i;

    bt_target_pipe #(.XLEN(XLEN), .STAGES(STAGES), .RV32C(1)) dut (
        .clk_i (clk), .rst_i (rst), .bus (bus)
    );
    bt_target_pipe #(.XLEN(XLEN), .STAGES(STAGES), .RV32C(0)) dut4 (
        .clk_i (clk), .rst_i (rst), .bus (bus4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_a_sel_e a, input imm_b_sel_e b, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] ii, input logic [31:0] ib,
                         input logic [31:0] ij, input logic c);
        bus.bt_a_mux_sel_i        = a;
        bus.bt_b_mux_sel_i        = b;
        bus.pc_i                  = pc;
        bus.rf_rdata_a_i          = rs1;
        bus.imm_i_type_i          = ii;
        bus.imm_b_type_i          = ib;
        bus.imm_j_type_i          = ij;
        bus.instr_is_compressed_i = c;
    endtask

    // Send one op into an empty pipe, check latency, then check both instances.
    task automatic one(input string tag,
                       input logic [31:0] t,  input logic [31:0] l,  input logic m,
                       input logic [31:0] t4, input logic [31:0] l4, input logic m4);
        bus.valid_i = 1'b1;
        tick;
        bus.valid_i = 1'b0;
        chk({tag, ".lat"}, bus.valid_o, 1'b0);
        tick;
        chk({tag, ".v"},  bus.valid_o,      1'b1);
        chk({tag, ".t"},  bus.target_o,     t);
        chk({tag, ".l"},  bus.link_o,       l);
        chk({tag, ".m"},  bus.misaligned_o, m);
        chk({tag, ".t4"}, bus4.target_o,    t4);
        chk({tag, ".l4"}, bus4.link_o,      l4);
        chk({tag, ".m4"}, bus4.misaligned_o, m4);
        tick;  // retire with ready_i=1
        chk({tag, ".drain"}, bus.valid_o, 1'b0);
    endtask

    logic [31:0] expq[$];
    logic [31:0] held, exp_t;
    logic        hold;
    int          sent, got, last_ret;

    initial begin
        rst         = 1'b1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        drive(OP_A_CURRPC, IMM_B_J, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h20, 1'b0);

        // ---- reset held 3 cycles with valid_i=1 ----
        repeat (3) tick;
        chk("rst.valid", bus.valid_o,      1'b0);
        chk("rst.occ",   bus.occupancy_o,  2'd0);
        chk("rst.tgt",   bus.target_o,     32'h0);
        chk("rst.link",  bus.link_o,       32'h0);
        chk("rst.mis",   bus.misaligned_o, 1'b0);
        chk("rst.rdy",   bus.ready_o,      1'b1);
        rst         = 1'b0;
        bus.valid_i = 1'b0;
        tick;

        // ---- directed single ops ----
        drive(OP_A_CURRPC, IMM_B_J, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h20, 1'b0);
        one("jal", 32'h1020, 32'h1004, 1'b0, 32'h1020, 32'h1004, 1'b0);
        drive(OP_A_REG_A, IMM_B_I, 32'h3000, 32'h2003, 32'h4, 32'h0, 32'h0, 1'b0);
        one("jalr", 32'h2006, 32'h3004, 1'b0, 32'h2006, 32'h3004, 1'b1);
        drive(OP_A_REG_A, IMM_B_I, 32'h3000, 32'h2000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
        one("jalr_neg", 32'h1FFE, 32'h3004, 1'b0, 32'h1FFE, 32'h3004, 1'b1);
        drive(OP_A_REG_A, IMM_B_B, 32'h3000, 32'h2003, 32'h0, 32'h0, 32'h0, 1'b0);
        one("noclr", 32'h2003, 32'h3004, 1'b1, 32'h2003, 32'h3004, 1'b1);
        drive(OP_A_CURRPC, IMM_B_B, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 32'h0, 1'b1);
        one("wrap", 32'h0000_0004, 32'hFFFF_FFFE, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0);
        drive(OP_A_IMM, IMM_B_U, 32'h500, 32'h9999, 32'h7, 32'h7, 32'h7, 1'b0);
        one("dflt", 32'h504, 32'h504, 1'b0, 32'h504, 32'h504, 1'b0);
        drive(OP_A_CURRPC, IMM_B_INCR_PC, 32'h600, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        one("cinc", 32'h602, 32'h602, 1'b0, 32'h604, 32'h604, 1'b0);
        drive(OP_A_CURRPC, IMM_B_J, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h2, 1'b0);
        one("half", 32'h1002, 32'h1004, 1'b0, 32'h1002, 32'h1004, 1'b1);

        // ---- backpressure: 6 ops, ready_i low for first 4 cycles ----
        sent = 0; got = 0; last_ret = -1; hold = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            bus.ready_i = (cyc < 4) ? 1'b0 : 1'b1;
            if (sent < 6) begin
                drive(OP_A_CURRPC, IMM_B_INCR_PC, 32'h100 * (sent + 1), 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
                bus.valid_i = 1'b1;
            end else begin
                bus.valid_i = 1'b0;
            end
            #1;
            if (hold) begin
                chk("bp.stable_v", bus.valid_o,  1'b1);
                chk("bp.stable_t", bus.target_o, held);
            end
            hold = bus.valid_o && !bus.ready_i;
            held = bus.target_o;
            if (!bus.ready_i) begin
                if (bus.occupancy_o == 2'(STAGES)) chk("bp.full_rdy", bus.ready_o, 1'b0);
                else                               chk("bp.part_rdy", bus.ready_o, 1'b1);
            end
            if (bus.valid_o && bus.ready_i) begin
                if (expq.size() == 0) begin
                    chk("bp.dup", bus.valid_o, 1'b0);
                end else begin
                    exp_t = expq.pop_front();
                    chk("bp.order", bus.target_o, exp_t);
                end
                if (last_ret >= 0) chk("bp.gap", 32'(cyc - last_ret), 32'd1);
                last_ret = cyc;
                got++;
            end
            if (bus.valid_i && bus.ready_o) begin
                expq.push_back(32'h100 * (sent + 1) + 32'h4);
                sent++;
            end
            @(posedge clk);
            #1;
        end
        bus.valid_i = 1'b0;
        chk("bp.got",  32'(got),  32'd6);
        chk("bp.sent", 32'(sent), 32'd6);
        tick;
        chk("bp.empty", bus.valid_o, 1'b0);

        // ---- flush with pipe full and valid_i=1 ----
        bus.ready_i = 1'b0;
        drive(OP_A_CURRPC, IMM_B_J, 32'h4000, 32'h0, 32'h0, 32'h0, 32'h10, 1'b0);
        bus.valid_i = 1'b1;
        tick;
        tick;
        chk("fl.occ_full", bus.occupancy_o, 2'd2);
        drive(OP_A_CURRPC, IMM_B_J, 32'hDEAD_0000, 32'h0, 32'h0, 32'h0, 32'h10, 1'b0);
        bus.flush_i = 1'b1;
        #1;
        chk("fl.rdy", bus.ready_o, 1'b0);
        tick;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("fl.valid", bus.valid_o,     1'b0);
        chk("fl.occ",   bus.occupancy_o, 2'd0);
        bus.ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("fl.ghost", bus.valid_o, 1'b0);
        end

        // ---- flush on an empty pipe drops the same-cycle input op ----
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        tick;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("fl2.occ", bus.occupancy_o, 2'd0);
        tick;
        chk("fl2.valid", bus.valid_o, 1'b0);

        // ---- reset mid-stream discards ops ----
        drive(OP_A_CURRPC, IMM_B_J, 32'h5000, 32'h0, 32'h0, 32'h0, 32'h8, 1'b0);
        bus.valid_i = 1'b1;
        tick;
        bus.valid_i = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mrst.valid", bus.valid_o,     1'b0);
        chk("mrst.occ",   bus.occupancy_o, 2'd0);
        chk("mrst.tgt",   bus.target_o,    32'h0);
        tick;
        chk("mrst.ghost", bus.valid_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
